// File: rtl/adder_seq_ctrl.sv
// Multi-cycle adder: one shared 2-bit ripple slice is stepped over WIDTH/2 cycles,
// with the inter-slice carry held in a flop and a valid/ready start handshake.

module adder2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       ci_i,
  output logic [1:0] s_o,
  output logic       co_o
);
  assign {co_o, s_o} = 3'(a_i) + 3'(b_i) + 3'(ci_i);
endmodule

module adder_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N     = WIDTH / 2;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       slice_s;
  logic             slice_co;

  adder2 u_slice (
    .a_i  (a_q[1:0]),
    .b_i  (b_q[1:0]),
    .ci_i (c_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          part_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned k = 0; k < N; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            part_d[2*k +: 2] = slice_s;
          end
        end
        a_d   = a_q >> 2;
        b_d   = b_q >> 2;
        c_d   = slice_co;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          sum_d   = part_d;
          cout_d  = slice_co;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign start_ready = ready_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized and directed bench for adder_seq_ctrl at WIDTH=8, 4 and 2,
// checked against plain a+b+cin arithmetic and handshake timing rules.

module tb_adder_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // WIDTH=8 instance
  logic       rst8, sv8, rdy8, ci8, co8, busy8, done8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=4 instance
  logic       rst4, sv4, rdy4, ci4, co4, busy4, done4;
  logic [3:0] a4, b4, sum4;
  // WIDTH=2 instance
  logic       rst2, sv2, rdy2, ci2, co2, busy2, done2;
  logic [1:0] a2, b2, sum2;

  adder_seq_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start_valid(sv8), .start_ready(rdy8),
    .a(a8), .b(b8), .cin(ci8), .sum(sum8), .cout(co8), .busy(busy8), .done(done8)
  );
  adder_seq_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .start_valid(sv4), .start_ready(rdy4),
    .a(a4), .b(b4), .cin(ci4), .sum(sum4), .cout(co4), .busy(busy4), .done(done4)
  );
  adder_seq_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst2), .start_valid(sv2), .start_ready(rdy2),
    .a(a2), .b(b2), .cin(ci2), .sum(sum2), .cout(co2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation; result must land exactly 4 cycles after accept
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    logic [7:0] prev_s;
    logic       prev_c;
    logic [8:0] exp;
    int         cyc;
    exp = 9'(ta) + 9'(tb) + 9'(tc);
    cyc = 0;
    while (!rdy8 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("ready8_before_accept", 32'(rdy8), 32'd1);
    prev_s = sum8;
    prev_c = co8;
    sv8 = 1'b1; a8 = ta; b8 = tb; ci8 = tc;
    tick();
    sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    cyc = 0;
    while (!done8 && cyc < 20) begin
      check("sum8_held", 32'({prev_c, prev_s}), 32'({co8, sum8}));
      check("ready8_low_busy8_high", 32'({rdy8, busy8}), 32'b01);
      tick();
      cyc++;
    end
    check("latency8", 32'(cyc), 32'd4);
    check("result8", 32'({co8, sum8}), 32'(exp));
    check("ready8_low_in_done", 32'({rdy8, busy8}), 32'b01);
    tick();
    check("done8_one_cycle", 32'(done8), 32'd0);
    check("idle8_ready_busy", 32'({rdy8, busy8}), 32'b10);
    check("result8_held", 32'({co8, sum8}), 32'(exp));
  endtask

  logic [16:0] ops [0:47];

  initial begin
    int cyc;
    int ndone;
    logic [16:0] op;

    rst8 = 1'b1; rst4 = 1'b1; rst2 = 1'b1;
    sv8 = 1'b1; sv4 = 1'b0; sv2 = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    a4 = '0; b4 = '0; ci4 = 1'b0;
    a2 = '0; b2 = '0; ci2 = 1'b0;
    tick(); tick();
    check("reset_sum_cout", 32'({co8, sum8}), 32'd0);
    check("reset_done_busy", 32'({done8, busy8}), 32'd0);
    check("reset_ready", 32'(rdy8), 32'd1);
    sv8 = 1'b0;
    rst8 = 1'b0; rst4 = 1'b0; rst2 = 1'b0;
    tick();
    check("post_reset_idle", 32'({rdy8, busy8, done8, co8, sum8}), 32'h800);

    // Plan 1 and 2: overflow case, then held previous sum
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'h5A, 8'h3C, 1'b1);

    // Plan 3: start_valid during RUN is ignored
    sv8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
    tick();
    sv8 = 1'b0;
    tick();
    sv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    cyc = 2;
    while (!done8 && cyc < 20) begin
      tick();
      cyc++;
    end
    sv8 = 1'b0;
    check("ignore_latency", 32'(cyc - 1), 32'd4);
    check("ignore_result", 32'({co8, sum8}), 32'h030);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done8) ndone++;
    end
    check("ignore_no_second_done", 32'(ndone), 32'd0);
    check("ignore_result_held", 32'({co8, sum8}), 32'h030);

    // Plan 4: reset during RUN step 2 aborts without a done pulse
    sv8 = 1'b1; a8 = 8'h33; b8 = 8'h44; ci8 = 1'b0;
    tick();
    sv8 = 1'b0;
    tick(); tick();
    rst8 = 1'b1;
    #1;
    check("abort_outputs", 32'({co8, sum8}), 32'd0);
    check("abort_busy_done", 32'({busy8, done8}), 32'd0);
    sv8 = 1'b1;
    tick(); tick();
    check("abort_ready", 32'(rdy8), 32'd1);
    sv8 = 1'b0;
    rst8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done8 || busy8) ndone++;
    end
    check("abort_no_done_or_busy", 32'(ndone), 32'd0);
    run8(8'h80, 8'h80, 1'b0);

    // Randomized single operations
    for (int i = 0; i < 20; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Plan 5: start_valid held high; accept every 6 cycles at edges 0,6,12,...
    check("stream_start_idle", 32'(rdy8), 32'd1);
    for (int e = 0; e < 48; e++) begin
      sv8 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      ops[e] = {ci8, a8, b8};
      tick();
      if (e % 6 == 4) begin
        op = ops[e - 4];
        check("stream_done", 32'(done8), 32'd1);
        check("stream_result", 32'({co8, sum8}),
              32'(9'(op[15:8]) + 9'(op[7:0]) + 9'(op[16])));
      end else begin
        check("stream_no_done", 32'(done8), 32'd0);
      end
    end
    sv8 = 1'b0;
    tick(); tick();

    // Plan 6: WIDTH=4 exhaustive, latency 2
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int c = 0; c < 2; c++) begin
          sv4 = 1'b1; a4 = 4'(i); b4 = 4'(j); ci4 = 1'(c);
          tick();
          sv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
          cyc = 0;
          while (!done4 && cyc < 10) begin
            tick();
            cyc++;
          end
          check("latency4", 32'(cyc), 32'd2);
          check("result4", 32'({co4, sum4}), 32'(i + j + c));
          tick();
          check("done4_one_cycle", 32'({done4, rdy4}), 32'b01);
        end
      end
    end

    // WIDTH=2 exhaustive, single RUN cycle
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        for (int c = 0; c < 2; c++) begin
          sv2 = 1'b1; a2 = 2'(i); b2 = 2'(j); ci2 = 1'(c);
          tick();
          sv2 = 1'b0;
          cyc = 0;
          while (!done2 && cyc < 10) begin
            tick();
            cyc++;
          end
          check("latency2", 32'(cyc), 32'd1);
          check("result2", 32'({co2, sum2}), 32'(i + j + c));
          tick();
          check("done2_one_cycle", 32'({done2, rdy2}), 32'b01);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
